// File: rtl/mux8_rr_arbiter_if.sv
// Bundle of request, data and grant signals between eight requesters and the
// round-robin arbiter that owns the shared 8:1 output mux.
interface mux8_rr_arbiter_if;
   logic [7:0] req;
   logic [7:0] in;
   logic [7:0] gnt;
   logic [2:0] sel;
   logic       valid;
   logic       out;

   modport master (
      output req,
      output in,
      input  gnt,
      input  sel,
      input  valid,
      input  out
   );

   modport slave (
      input  req,
      input  in,
      output gnt,
      output sel,
      output valid,
      output out
   );
endinterface

// File: rtl/mux8_rr_arbiter.sv
// Eight-way round-robin arbiter with a bounded hold time, steering the shared
// 8:1 mux to the current owner's data bit.
module mux8_rr_arbiter #(
   parameter int MAX_HOLD = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   mux8_rr_arbiter_if.slave bus
);

   localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   state_t     state_reg, state_next;
   logic [2:0] sel_reg, sel_next;
   logic [2:0] ptr_reg, ptr_next;
   logic [3:0] hold_cnt_reg, hold_cnt_next;

   logic [7:0] rot_req;
   logic [7:0] gnt_onehot;
   logic [7:0] others;
   logic [2:0] pick_off;
   logic [2:0] pick_idx;
   logic       any_req;
   logic       owner_req;
   logic       timeout;
   logic       valid;

   // Rotate requests so that position 0 is the pointer; the lowest set bit of
   // the rotated vector is then the round-robin winner.
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_lane
         assign rot_req[gi]    = bus.req[ptr_reg + 3'(gi)];
         assign gnt_onehot[gi] = valid && (sel_reg == 3'(gi));
      end
   endgenerate

   always_comb begin
      pick_off = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (rot_req[i]) begin
            pick_off = 3'(i);
         end
      end
   end

   assign valid     = (state_reg == GRANT);
   assign any_req   = |bus.req;
   assign pick_idx  = ptr_reg + pick_off;
   assign owner_req = bus.req[sel_reg];
   assign others    = bus.req & ~gnt_onehot;
   // Since ptr already sits one past the owner, re-arbitrating on timeout
   // naturally leaves the owner for last.
   assign timeout   = owner_req && (hold_cnt_reg == HOLD_LAST) && (others != 8'h00);

   always_comb begin
      state_next    = state_reg;
      sel_next      = sel_reg;
      ptr_next      = ptr_reg;
      hold_cnt_next = hold_cnt_reg;
      case (state_reg)
         IDLE: begin
            if (any_req) begin
               state_next    = GRANT;
               sel_next      = pick_idx;
               ptr_next      = pick_idx + 3'd1;
               hold_cnt_next = 4'd0;
            end
         end
         GRANT: begin
            if (owner_req && !timeout) begin
               hold_cnt_next = (hold_cnt_reg == HOLD_LAST) ? 4'd0 : hold_cnt_reg + 4'd1;
            end else if (any_req) begin
               sel_next      = pick_idx;
               ptr_next      = pick_idx + 3'd1;
               hold_cnt_next = 4'd0;
            end else begin
               state_next    = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         sel_reg      <= 3'd0;
         ptr_reg      <= 3'd0;
         hold_cnt_reg <= 4'd0;
      end else begin
         state_reg    <= state_next;
         sel_reg      <= sel_next;
         ptr_reg      <= ptr_next;
         hold_cnt_reg <= hold_cnt_next;
      end
   end

   assign bus.gnt   = gnt_onehot;
   assign bus.sel   = sel_reg;
   assign bus.valid = valid;
   assign bus.out   = valid & bus.in[sel_reg];

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Scoreboard bench for mux8_rr_arbiter: a behavioural arbiter model predicts
// each cycle's grant, directed scenarios add fixed expectations on top.
module tb_mux8_rr_arbiter;

   localparam int MAX_HOLD   = 4;
   localparam int WAIT_LIMIT = 7 * MAX_HOLD + 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   mux8_rr_arbiter_if bus();
   mux8_rr_arbiter_if bus1();

   mux8_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   mux8_rr_arbiter #(.MAX_HOLD(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] gnt;
      logic [2:0] sel;
      logic       valid;
      logic       out;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   int   m_sel;
   int   m_ptr;
   int   m_hold;
   bit   m_valid;
   int   wait_cnt [8];

   task automatic model_reset();
      m_sel   = 0;
      m_ptr   = 0;
      m_hold  = 0;
      m_valid = 0;
      for (int i = 0; i < 8; i++) wait_cnt[i] = 0;
      exp_q.delete();
   endtask

   task automatic model_step(input logic [7:0] r);
      int         pick;
      logic [7:0] owner_bit;
      pick      = -1;
      owner_bit = m_valid ? (8'h01 << m_sel) : 8'h00;
      if (m_valid && r[m_sel] && !(m_hold == MAX_HOLD - 1 && (r & ~owner_bit) != 8'h00)) begin
         m_hold = (m_hold == MAX_HOLD - 1) ? 0 : m_hold + 1;
      end else if (r != 8'h00) begin
         for (int k = 0; k < 8; k++) begin
            if (pick < 0 && r[(m_ptr + k) % 8]) pick = (m_ptr + k) % 8;
         end
         m_sel   = pick;
         m_ptr   = (pick + 1) % 8;
         m_hold  = 0;
         m_valid = 1;
      end else begin
         m_valid = 0;
      end
   endtask

   // Apply one cycle of stimulus, record the prediction, and land 1 time unit
   // after the sampling edge.
   task automatic drive(input logic [7:0] r, input logic [7:0] d);
      exp_t e;
      bus.req = r;
      bus.in  = d;
      model_step(r);
      e.valid = m_valid;
      e.sel   = 3'(m_sel);
      e.gnt   = m_valid ? (8'h01 << m_sel) : 8'h00;
      e.out   = m_valid ? d[m_sel] : 1'b0;
      exp_q.push_back(e);
      $display("txn t=%0t req=%h in=%h exp gnt=%h sel=%0d valid=%b out=%b",
               $time, r, d, e.gnt, e.sel, e.valid, e.out);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.req  = 8'h00;
      bus1.req = 8'h00;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      exp_t e;
      bus.req  = 8'h00;
      bus.in   = 8'h00;
      bus1.req = 8'h00;
      bus1.in  = 8'h00;
      #1;
      rst_n = 1'b0;
      #2;
      n_checks++;
      if ({bus.gnt, bus.sel, bus.valid, bus.out} !== 13'h0)
         $display("FAIL reset_async: got gnt=%h sel=%0d valid=%b out=%b want all zero",
                  bus.gnt, bus.sel, bus.valid, bus.out);
      else n_pass++;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      drive(8'h00, 8'hFF);
      e = exp_q.pop_front();
      n_checks++;
      if ({bus.gnt, bus.sel, bus.valid, bus.out} !== e)
         $display("FAIL reset_idle: got %h/%0d/%b/%b want %h/%0d/%b/%b",
                  bus.gnt, bus.sel, bus.valid, bus.out, e.gnt, e.sel, e.valid, e.out);
      else n_pass++;
   endtask

   task automatic test_single();
      exp_t e;
      drive(8'h04, 8'hAA);
      e = exp_q.pop_front();
      n_checks++;
      if ({bus.gnt, bus.sel, bus.valid, bus.out} !== e)
         $display("FAIL single_sb: got %h/%0d/%b/%b want %h/%0d/%b/%b",
                  bus.gnt, bus.sel, bus.valid, bus.out, e.gnt, e.sel, e.valid, e.out);
      else n_pass++;
      n_checks++;
      if ({bus.gnt, bus.sel, bus.valid, bus.out} !== {8'h04, 3'd2, 1'b1, 1'b0})
         $display("FAIL single_grant: got gnt=%h sel=%0d valid=%b out=%b want gnt=04 sel=2 valid=1 out=0",
                  bus.gnt, bus.sel, bus.valid, bus.out);
      else n_pass++;
      drive(8'h00, 8'hAA);
      e = exp_q.pop_front();
      n_checks++;
      if ({bus.gnt, bus.sel, bus.valid, bus.out} !== e)
         $display("FAIL single_release_sb: got %h/%0d/%b/%b want %h/%0d/%b/%b",
                  bus.gnt, bus.sel, bus.valid, bus.out, e.gnt, e.sel, e.valid, e.out);
      else n_pass++;
      n_checks++;
      if (bus.gnt !== 8'h00 || bus.valid !== 1'b0)
         $display("FAIL single_release: got gnt=%h valid=%b want gnt=00 valid=0",
                  bus.gnt, bus.valid);
      else n_pass++;
   endtask

   task automatic test_rotation();
      exp_t e;
      int   want_sel;
      do_reset();
      for (int c = 0; c < 33; c++) begin
         drive(8'hFF, 8'hF0);
         e = exp_q.pop_front();
         n_checks++;
         if ({bus.gnt, bus.sel, bus.valid, bus.out} !== e)
            $display("FAIL rotation_sb c%0d: got %h/%0d/%b/%b want %h/%0d/%b/%b", c,
                     bus.gnt, bus.sel, bus.valid, bus.out, e.gnt, e.sel, e.valid, e.out);
         else n_pass++;
         want_sel = (c / 4) % 8;
         n_checks++;
         if (bus.sel !== 3'(want_sel) || bus.out !== (want_sel >= 4) || bus.valid !== 1'b1)
            $display("FAIL rotation_seq c%0d: got sel=%0d out=%b valid=%b want sel=%0d out=%b valid=1",
                     c, bus.sel, bus.out, bus.valid, want_sel, (want_sel >= 4));
         else n_pass++;
      end
   endtask

   task automatic test_wrap();
      exp_t e;
      do_reset();
      drive(8'h80, 8'h00);
      e = exp_q.pop_front();
      n_checks++;
      if ({bus.gnt, bus.sel, bus.valid, bus.out} !== e)
         $display("FAIL wrap_owner7: got %h/%0d/%b/%b want %h/%0d/%b/%b",
                  bus.gnt, bus.sel, bus.valid, bus.out, e.gnt, e.sel, e.valid, e.out);
      else n_pass++;
      drive(8'h03, 8'h01);
      e = exp_q.pop_front();
      n_checks++;
      if ({bus.gnt, bus.sel, bus.valid, bus.out} !== e)
         $display("FAIL wrap_sb: got %h/%0d/%b/%b want %h/%0d/%b/%b",
                  bus.gnt, bus.sel, bus.valid, bus.out, e.gnt, e.sel, e.valid, e.out);
      else n_pass++;
      n_checks++;
      if ({bus.gnt, bus.sel, bus.valid, bus.out} !== {8'h01, 3'd0, 1'b1, 1'b1})
         $display("FAIL wrap_grant0: got gnt=%h sel=%0d valid=%b out=%b want gnt=01 sel=0 valid=1 out=1",
                  bus.gnt, bus.sel, bus.valid, bus.out);
      else n_pass++;
   endtask

   task automatic test_solo_hold();
      exp_t e;
      do_reset();
      for (int c = 0; c < 20; c++) begin
         drive(8'h20, 8'h20);
         e = exp_q.pop_front();
         n_checks++;
         if ({bus.gnt, bus.sel, bus.valid, bus.out} !== e)
            $display("FAIL solo_sb c%0d: got %h/%0d/%b/%b want %h/%0d/%b/%b", c,
                     bus.gnt, bus.sel, bus.valid, bus.out, e.gnt, e.sel, e.valid, e.out);
         else n_pass++;
         n_checks++;
         if (bus.gnt !== 8'h20 || bus.out !== 1'b1)
            $display("FAIL solo_hold c%0d: got gnt=%h out=%b want gnt=20 out=1", c, bus.gnt, bus.out);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      #3;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus.gnt !== 8'h00 || bus.valid !== 1'b0 || bus.out !== 1'b0)
         $display("FAIL reset_mid: got gnt=%h valid=%b out=%b want gnt=00 valid=0 out=0",
                  bus.gnt, bus.valid, bus.out);
      else n_pass++;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      drive(8'h80, 8'h80);
      e = exp_q.pop_front();
      n_checks++;
      if ({bus.gnt, bus.sel, bus.valid, bus.out} !== e)
         $display("FAIL reset_resume_sb: got %h/%0d/%b/%b want %h/%0d/%b/%b",
                  bus.gnt, bus.sel, bus.valid, bus.out, e.gnt, e.sel, e.valid, e.out);
      else n_pass++;
      n_checks++;
      if ({bus.gnt, bus.sel, bus.valid, bus.out} !== {8'h80, 3'd7, 1'b1, 1'b1})
         $display("FAIL reset_resume: got gnt=%h sel=%0d valid=%b out=%b want gnt=80 sel=7 valid=1 out=1",
                  bus.gnt, bus.sel, bus.valid, bus.out);
      else n_pass++;
   endtask

   task automatic test_in_comb();
      #2;
      bus.in = 8'h7F;
      #1;
      n_checks++;
      if (bus.out !== 1'b0 || bus.gnt !== 8'h80)
         $display("FAIL in_comb_low: got out=%b gnt=%h want out=0 gnt=80", bus.out, bus.gnt);
      else n_pass++;
      bus.in = 8'h80;
      #1;
      n_checks++;
      if (bus.out !== 1'b1 || bus.gnt !== 8'h80)
         $display("FAIL in_comb_high: got out=%b gnt=%h want out=1 gnt=80", bus.out, bus.gnt);
      else n_pass++;
   endtask

   task automatic test_max_hold1();
      do_reset();
      bus1.req = 8'h03;
      bus1.in  = 8'h02;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk);
         #1;
         $display("txn t=%0t hold1 req=%h sel=%0d valid=%b", $time, bus1.req, bus1.sel, bus1.valid);
         n_checks++;
         if (bus1.sel !== 3'(c % 2) || bus1.valid !== 1'b1 || bus1.out !== (c % 2 == 1))
            $display("FAIL hold1_rotate c%0d: got sel=%0d valid=%b out=%b want sel=%0d valid=1 out=%b",
                     c, bus1.sel, bus1.valid, bus1.out, c % 2, (c % 2 == 1));
         else n_pass++;
      end
      bus1.req = 8'h00;
   endtask

   task automatic test_random();
      exp_t       e;
      logic [7:0] r;
      int         maxw;
      do_reset();
      r = 8'h00;
      for (int cyc = 0; cyc < 1000; cyc++) begin
         for (int i = 0; i < 8; i++) begin
            if (r[i]) begin
               if (bus.gnt[i] && $urandom_range(0, 2) == 0) r[i] = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
               r[i] = 1'b1;
            end
         end
         drive(r, 8'($urandom));
         e = exp_q.pop_front();
         n_checks++;
         if ({bus.gnt, bus.sel, bus.valid, bus.out} !== e)
            $display("FAIL random_sb cyc%0d: got %h/%0d/%b/%b want %h/%0d/%b/%b", cyc,
                     bus.gnt, bus.sel, bus.valid, bus.out, e.gnt, e.sel, e.valid, e.out);
         else n_pass++;
         n_checks++;
         if (!$onehot0(bus.gnt) || (bus.valid && bus.out !== bus.in[bus.sel]))
            $display("FAIL random_onehot cyc%0d: got gnt=%h out=%b in=%h sel=%0d want one-hot gnt and out=in[sel]",
                     cyc, bus.gnt, bus.out, bus.in, bus.sel);
         else n_pass++;
         maxw = 0;
         for (int i = 0; i < 8; i++) begin
            if (bus.req[i] && !bus.gnt[i]) wait_cnt[i]++;
            else wait_cnt[i] = 0;
            if (wait_cnt[i] > maxw) maxw = wait_cnt[i];
         end
         n_checks++;
         if (maxw > WAIT_LIMIT)
            $display("FAIL random_wait cyc%0d: got wait=%0d want <= %0d", cyc, maxw, WAIT_LIMIT);
         else n_pass++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no completion want finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_single();
      test_rotation();
      test_wrap();
      test_solo_hold();
      test_reset_mid();
      test_in_comb();
      test_max_hold1();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
